// File: rtl/operand_fetch_block_pkg.sv
// operand_fetch_block_pkg: pipeline-wide widths and the R0 address constant
package operand_fetch_block_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG = 2 ** ADDR_W;
    localparam int OP_W = 4;
    localparam logic [ADDR_W-1:0] R0 = '0;
endpackage

// File: rtl/operand_fetch_block_regfile_2r1w.sv
// regfile_2r1w: register file with two combinational reads, one synchronous write, R0 hardwired to zero
module regfile_2r1w
    import operand_fetch_block_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    logic [NREG-1:0][DATA_W-1:0] mem;
    always_ff @(posedge clk) begin
        if (reset) mem <= '0;
        else if (we && waddr != R0) mem[waddr] <= wdata;
    end
    always_comb begin
        rdata_a = (ra == R0) ? '0 : mem[ra];
        rdata_b = (rb == R0) ? '0 : mem[rb];
    end
endmodule

// File: rtl/operand_fetch_block.sv
// operand_fetch_block: register read with write-back bypass, scoreboard hazard stall, registered output stage
module operand_fetch_block
    import operand_fetch_block_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [OP_W-1:0]   id_op,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_wen,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              of_valid,
    input  logic              of_ready,
    output logic [OP_W-1:0]   of_op,
    output logic [DATA_W-1:0] of_a,
    output logic [DATA_W-1:0] of_b,
    output logic [ADDR_W-1:0] of_rd,
    output logic              of_wen,
    output logic [NREG-1:0]   busy_mask
);
    logic [DATA_W-1:0] rf_a, rf_b, op_a, op_b;
    logic [NREG-1:0] clr, set, pend;
    logic hazard, accept;
    regfile_2r1w u_rf (
        .clk(clk), .reset(reset), .we(wb_valid), .waddr(wb_addr), .wdata(wb_data),
        .ra(id_rs), .rb(id_rt), .rdata_a(rf_a), .rdata_b(rf_b)
    );
    always_comb begin
        op_a = (id_rs == R0) ? '0 : (wb_valid && wb_addr == id_rs) ? wb_data : rf_a;
        op_b = (id_rt == R0) ? '0 : (wb_valid && wb_addr == id_rt) ? wb_data : rf_b;
        clr = wb_valid ? (NREG'(1) << wb_addr) : '0;
        pend = busy_mask & ~clr;
        hazard = pend[id_rs] | pend[id_rt] | (id_wen & pend[id_rd]);
        id_ready = !reset && !hazard && (!of_valid || of_ready);
        accept = id_valid && id_ready;
        set = (accept && id_wen && id_rd != R0) ? (NREG'(1) << id_rd) : '0;
    end
    // set is OR'd after the clear so a re-issued writer keeps its register busy
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_mask <= '0;
            of_valid <= 1'b0;
            of_op <= '0;
            of_a <= '0;
            of_b <= '0;
            of_rd <= '0;
            of_wen <= 1'b0;
        end else begin
            busy_mask <= (busy_mask & ~clr) | set;
            if (accept) begin
                of_valid <= 1'b1;
                of_op <= id_op;
                of_a <= op_a;
                of_b <= op_b;
                of_rd <= id_rd;
                of_wen <= id_wen;
            end else if (of_ready) begin
                of_valid <= 1'b0;
            end
        end
    end
endmodule
